imem_boot_loader: RTL and testbench

- Byte-stream program loader that sits directly upstream of the single-cycle RISC-V processor.
- Receives a length-prefixed, checksummed image over a valid/ready byte interface.
- Assembles little-endian 32-bit words and writes them into instruction memory from word 0 upward.
- Holds the processor in reset until the image is fully loaded and verified; replaces file-based memory preload for hardware bring-up.

---
 rtl/imem_boot_loader_if.sv | 21 ++
 rtl/imem_boot_loader.sv | 110 +++++++++++
 tb/tb_imem_boot_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream receive and instruction-memory write bundle for the boot loader
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - length-prefixed, XOR-checksummed byte image loader into instruction memory
module imem_boot_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_boot_loader_if.master   bus,
    output logic                 core_rst,
    output logic                 load_done,
    output logic                 load_error,
    output logic [15:0]          words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_LIMIT = 17'(IMEM_DEPTH);

    state_t      state;
    logic [15:0] len;
    logic [7:0]  xor_acc;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        accept;

    assign accept = bus.rx_valid && bus.rx_ready;

    // words_loaded doubles as the write index: it bumps on the same edge that raises imem_we,
    // so the pulse for word k carries address k while the counter already reads k+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_LEN_LO;
            len            <= '0;
            xor_acc        <= '0;
            byte_idx       <= '0;
            word_buf       <= '0;
            bus.rx_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_rst       <= 1'b1;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
            words_loaded   <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            if (accept) begin
                unique case (state)
                    S_LEN_LO: begin
                        len[7:0] <= bus.rx_data;
                        xor_acc  <= xor_acc ^ bus.rx_data;
                        state    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len[15:8] <= bus.rx_data;
                        xor_acc   <= xor_acc ^ bus.rx_data;
                        if ({1'b0, bus.rx_data, len[7:0]} > DEPTH_LIMIT) begin
                            state        <= S_ERROR;
                            bus.rx_ready <= 1'b0;
                            load_error   <= 1'b1;
                        end else if ({bus.rx_data, len[7:0]} == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        xor_acc  <= xor_acc ^ bus.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            2'd3: begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= words_loaded[ADDR_W-1:0];
                                bus.imem_wdata <= {bus.rx_data, word_buf};
                                words_loaded   <= words_loaded + 16'd1;
                                if (words_loaded == len - 16'd1) begin
                                    state <= S_CHECK;
                                end
                            end
                        endcase
                    end
                    S_CHECK: begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == xor_acc) begin
                            state     <= S_DONE;
                            core_rst  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - vector-table and scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rst;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();

    imem_boot_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          writes_seen;
    int          last_addr;

    int          m_pos;
    logic [15:0] m_len;
    logic [31:0] m_word;
    bit          m_dead;

    task automatic model_reset();
        m_pos  = 0;
        m_len  = '0;
        m_word = '0;
        m_dead = 0;
        exp_q.delete();
        writes_seen = 0;
        last_addr   = -1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pos == 0) begin
            m_len[7:0] = b;
        end else if (m_pos == 1) begin
            m_len[15:8] = b;
            if (int'(m_len) > DEPTH) m_dead = 1;
        end else if (!m_dead && (m_pos - 2) < 4 * int'(m_len)) begin
            m_word[8*((m_pos-2)%4) +: 8] = b;
            if ((m_pos - 2) % 4 == 3) exp_q.push_back({AW'((m_pos - 2) / 4), m_word});
        end
        m_pos++;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.imem_we) begin
            writes_seen++;
            last_addr = int'(bus.imem_addr);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, no write expected", bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
                check("write_data", bus.imem_wdata, mon_e.data);
                check("words_at_write", 32'(words_loaded), 32'(mon_e.addr) + 32'd1);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %0h not accepted, rx_ready=%0b expected 1", b, bus.rx_ready);
        end else begin
            @(posedge clk);
            model_byte(b);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_end(input logic done, input logic err, input int words, input int writes);
        check("load_done", 32'(load_done), 32'(done));
        check("load_error", 32'(load_error), 32'(err));
        check("core_rst", 32'(core_rst), 32'(!done));
        check("rx_ready_end", 32'(bus.rx_ready), 32'd0);
        repeat (4) @(negedge clk);
        bus.rx_valid = 1'b0;
        check("words_loaded", 32'(words_loaded), 32'(words));
        check("writes_seen", 32'(writes_seen), 32'(writes));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_sticky", 32'(load_done), 32'(done));
        check("error_sticky", 32'(load_error), 32'(err));
    endtask

    typedef struct packed {
        logic [87:0] stream;
        logic [7:0]  n_bytes;
        logic [1:0]  gap_mode;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_words;
        logic [7:0]  exp_writes;
    } vec_t;

    vec_t vecs[5];
    logic [7:0] nominal[11];

    initial begin
        #500000;
        $display("FAIL global_timeout: bench exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;

        vecs[0] = '{88'h02_00_93_00_50_00_33_81_10_00_63, 8'd11, 2'd0, 1'b1, 1'b0, 16'd2, 8'd2};
        vecs[1] = '{88'h02_00_93_00_50_00_33_81_10_00_64, 8'd11, 2'd0, 1'b0, 1'b1, 16'd2, 8'd2};
        vecs[2] = '{88'h01_04_00_00_00_00_00_00_00_00_00, 8'd2,  2'd0, 1'b0, 1'b1, 16'd0, 8'd0};
        vecs[3] = '{88'h00_00_00_00_00_00_00_00_00_00_00, 8'd3,  2'd2, 1'b1, 1'b0, 16'd0, 8'd0};
        vecs[4] = '{88'h02_00_93_00_50_00_33_81_10_00_63, 8'd11, 2'd1, 1'b1, 1'b0, 16'd2, 8'd2};
        for (int i = 0; i < 11; i++) nominal[i] = vecs[0].stream[87-8*i -: 8];

        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < int'(vecs[v].n_bytes); i++) begin
                send(vecs[v].stream[87-8*i -: 8]);
                if (i < int'(vecs[v].n_bytes) - 1) begin
                    if (vecs[v].gap_mode == 2'd1) idle(int'($urandom_range(0, 3)));
                    else if (vecs[v].gap_mode == 2'd2) idle(3);
                end
            end
            check_end(vecs[v].exp_done, vecs[v].exp_err, int'(vecs[v].exp_words), int'(vecs[v].exp_writes));
        end

        // Reset in the middle of a load, then reload the same image.
        do_reset();
        for (int i = 0; i < 6; i++) send(nominal[i]);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("midload_writes", 32'(writes_seen), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 11; i++) send(nominal[i]);
        check_end(1'b1, 1'b0, 2, 2);

        // Full-depth image: last word lands at IMEM_DEPTH-1.
        do_reset();
        cs = 8'h00 ^ 8'h04;
        send(8'h00);
        send(8'h04);
        for (int k = 0; k < DEPTH; k++) begin
            w = (32'(k) * 32'h9E3779B1) ^ 32'h0000_0013;
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ w[8*j +: 8];
                send(w[8*j +: 8]);
            end
        end
        send(cs);
        check_end(1'b1, 1'b0, DEPTH, DEPTH);
        check("last_addr", 32'(last_addr), 32'(DEPTH - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
